// File: rtl/mtl2_touch_event_ctrl.sv
// MTL2 touch controller: debounces the panel interrupt, reads STAT/X/Y over an
// Avalon-MM master, queues packed events in a FIFO and exposes them via a CSR slave.
// Optional build macro MTL2_TOUCH_DEBOUNCE_EN enables the DEBOUNCE state and counter.
module mtl2_touch_event_ctrl #(
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter int          FIFO_DEPTH      = 4,
  parameter int          TIMEOUT_CYCLES  = 255,
  parameter logic [31:0] TOUCH_BASE      = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        touch_int_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic        read_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  output logic [31:0] m_address,
  output logic        m_read,
  input  logic [31:0] m_readdata,
  input  logic        m_waitrequest
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

`ifdef MTL2_TOUCH_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, DEBOUNCE, RD_STAT, RD_X, RD_Y, PUSH, ERR} state_t;
`else
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;
  typedef enum logic [2:0] {IDLE, RD_STAT, RD_X, RD_Y, PUSH, ERR} state_t;
`endif

  state_t state, state_nxt;

  logic              sync1, sync2, fall;
  logic              pending;
  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_last, err_set;
  logic [7:0]        stat_r;
  logic [11:0]       x_r, y_r;
  logic [31:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              empty, full, push, push_ok, pop, ovf_set;
  logic              rd_stb, wr_stb;
  logic              enable, irq_en, overflow, error, busy;
  logic [31:0]       rd_mux;
  logic              unused_bits;

  assign unused_bits = ^{m_readdata[31:12], writedata[31:2]};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= touch_int_n;
      sync2 <= sync1;
    end
  end

  assign fall      = sync2 & ~sync1;
  assign wait_last = (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));
  assign busy      = (state != IDLE);

`ifdef MTL2_TOUCH_DEBOUNCE_EN
  logic [DB_W-1:0] db_cnt;

  always_ff @(posedge clk) begin
    if (reset || state != DEBOUNCE) db_cnt <= '0;
    else                            db_cnt <= db_cnt + DB_W'(1);
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    m_read    = 1'b0;
    m_address = TOUCH_BASE;
    err_set   = 1'b0;
    case (state)
      IDLE: begin
`ifdef MTL2_TOUCH_DEBOUNCE_EN
        if (enable && (fall || pending)) state_nxt = DEBOUNCE;
`else
        if (enable && (fall || pending)) state_nxt = RD_STAT;
`endif
      end
`ifdef MTL2_TOUCH_DEBOUNCE_EN
      DEBOUNCE: begin
        if (sync2)                                         state_nxt = IDLE;
        else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1))     state_nxt = RD_STAT;
      end
`endif
      RD_STAT: begin
        m_read = 1'b1;
        if (!m_waitrequest)  state_nxt = RD_X;
        else if (wait_last) begin
          state_nxt = ERR;
          err_set   = 1'b1;
        end
      end
      RD_X: begin
        m_read    = 1'b1;
        m_address = TOUCH_BASE + 32'd4;
        if (!m_waitrequest)  state_nxt = RD_Y;
        else if (wait_last) begin
          state_nxt = ERR;
          err_set   = 1'b1;
        end
      end
      RD_Y: begin
        m_read    = 1'b1;
        m_address = TOUCH_BASE + 32'd8;
        if (!m_waitrequest)  state_nxt = PUSH;
        else if (wait_last) begin
          state_nxt = ERR;
          err_set   = 1'b1;
        end
      end
      PUSH:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stall watchdog restarts on every state change so each read gets its own budget.
  always_ff @(posedge clk) begin
    if (reset || state_nxt != state) wait_cnt <= '0;
    else if (m_read)                 wait_cnt <= wait_cnt + WAIT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= 1'b0;
    end else if (state == IDLE && state_nxt != IDLE) begin
      pending <= 1'b0;
    end else if (fall && state != IDLE && enable) begin
      pending <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (state == RD_STAT && !m_waitrequest) stat_r <= m_readdata[7:0];
    if (state == RD_X    && !m_waitrequest) x_r    <= m_readdata[11:0];
    if (state == RD_Y    && !m_waitrequest) y_r    <= m_readdata[11:0];
  end

  // Event FIFO: a pop in the same cycle frees the slot a full-FIFO push needs.
  assign rd_stb  = chipselect & ~read_n;
  assign wr_stb  = chipselect & ~write_n;
  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign push    = (state == PUSH);
  assign pop     = rd_stb && (address == 2'd0) && !empty;
  assign push_ok = push && (!full || pop);
  assign ovf_set = push && full && !pop;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {stat_r, x_r, y_r};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    rd_mux = 32'h0;
    case (address)
      2'd0:    rd_mux = empty ? 32'h0 : mem[rd_ptr];
      2'd1:    rd_mux = {16'b0, {(8 - CNT_W){1'b0}}, count, 4'b0, busy, error, overflow, empty};
      2'd2:    rd_mux = {30'b0, irq_en, enable};
      default: rd_mux = 32'h0;
    endcase
  end

  // Sticky flags: a hardware set in the same cycle as a software clear wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      enable   <= 1'b0;
      irq_en   <= 1'b0;
      overflow <= 1'b0;
      error    <= 1'b0;
      irq      <= 1'b0;
      readdata <= 32'h0;
    end else begin
      if (wr_stb && address == 2'd2) {irq_en, enable} <= writedata[1:0];
      if (ovf_set)                                          overflow <= 1'b1;
      else if (wr_stb && address == 2'd3 && writedata[0])   overflow <= 1'b0;
      if (err_set)                                          error <= 1'b1;
      else if (wr_stb && address == 2'd3 && writedata[1])   error <= 1'b0;
      irq <= irq_en & ~empty;
      if (rd_stb) readdata <= rd_mux;
    end
  end

endmodule
